uart_rx_sync: RTL

//  Robust UART byte receiver (8N1) feeding the command engine's rx_ready/rx_data inputs.

---
 rtl/uart_rx_sync.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Purpose  : 8N1 UART byte receiver. Two-flop synchroniser on the serial
//             line, 3-sample majority vote at mid-bit, start-bit glitch
//             rejection and framing-error detection. All outputs are
//             registered single-cycle pulses in the clk domain.
//  Ports    : clk            - system clock
//             rst_n          - synchronous active-low reset
//             rx_serial_line - asynchronous serial input, idle high
//             rx_ready       - 1-cycle pulse, rx_data holds a new byte
//             rx_data[7:0]   - last good byte (LSB received first)
//             rx_frame_err   - 1-cycle pulse, stop bit sampled low
//             rx_busy        - high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_line,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int c_CNT_W = $clog2(CLK_PER_BIT);
    localparam int c_HALF  = CLK_PER_BIT / 2;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SAMP_A  = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_SAMP_B  = c_CNT_W'(c_HALF);
    localparam logic [c_CNT_W-1:0] c_SAMP_C  = c_CNT_W'(c_HALF + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_rxs;
    logic               r_prev;
    logic [2:0]         r_fill;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_s0;
    logic               r_s1;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shreg;

    logic               w_edge;
    logic               w_vote;
    logic               w_decide;

    // The synchroniser and prev flops come out of reset forced high. r_fill
    // tracks when prev genuinely reflects the pin, so a line that is already
    // low at reset release is never mistaken for a falling edge.
    assign w_edge   = r_fill[2] & r_prev & ~r_rxs;
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
    assign w_decide = (r_cnt == c_SAMP_C);
    assign rx_busy  = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sync1      <= 1'b1;
            r_rxs        <= 1'b1;
            r_prev       <= 1'b1;
            r_fill       <= 3'b000;
            r_cnt        <= c_CNT_ONE;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_bit_idx    <= 3'd0;
            r_shreg      <= 8'h00;
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_data      <= 8'h00;
        end else begin
            r_sync1      <= rx_serial_line;
            r_rxs        <= r_sync1;
            r_prev       <= r_rxs;
            r_fill       <= {r_fill[1:0], 1'b1};
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;

            if (r_cnt == c_SAMP_A) r_s0 <= r_rxs;
            if (r_cnt == c_SAMP_B) r_s1 <= r_rxs;
            r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_ONE;

            case (r_state)
                ST_IDLE: begin
                    // The edge-detect cycle itself is tick 0 of the start
                    // bit, so the timer enters START already at 1.
                    r_cnt <= c_CNT_ONE;
                    if (w_edge) r_state <= ST_START;
                end
                ST_START: begin
                    if (w_decide) begin
                        r_bit_idx <= 3'd0;
                        r_state   <= w_vote ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shreg   <= {w_vote, r_shreg[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets a start bit that follows
                    // with zero idle gap be caught.
                    if (w_decide) begin
                        if (w_vote) begin
                            rx_data  <= r_shreg;
                            rx_ready <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            r_state      <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_rxs) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
